// File: rtl/conv_tile_feeder.sv
// Tile feeder for the conv/max-pool engine: walks a row-major greyscale image in SRAM,
// gathers 4x4 tiles at stride 2 and hands each one to the engine, pacing on its result write.
module conv_tile_feeder #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [71:0]       cfg_kernel_0,
    input  logic [71:0]       cfg_kernel_1,
    input  logic [71:0]       cfg_kernel_2,
    input  logic [1:0]        cfg_shift,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [127:0]      image_4x4,
    output logic [71:0]       conv_kernel_0,
    output logic [71:0]       conv_kernel_1,
    output logic [71:0]       conv_kernel_2,
    output logic [1:0]        shift,
    output logic              input_re,
    output logic [ADDR_W-1:0] input_addr,
    input  logic              result_we,
    output logic              busy,
    output logic              done_all
);

    localparam int TX = (IMG_W - 4) / 2 + 1;
    localparam int TY = (IMG_H - 4) / 2 + 1;
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW2_STEP = ADDR_W'(2 * IMG_W);
    localparam logic [ADDR_W-1:0] LAST_TX   = ADDR_W'(TX - 1);
    localparam logic [ADDR_W-1:0] LAST_TY   = ADDR_W'(TY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [4:0]        fetch_cnt;
    logic [ADDR_W-1:0] tx;
    logic [ADDR_W-1:0] ty;
    logic [ADDR_W-1:0] tile_idx;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] tile_base;
    logic              rd_pend;
    logic [3:0]        rd_idx;
    logic              last_tile;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n     = rst_sync[1];
    assign last_tile = (tx == LAST_TX) && (ty == LAST_TY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_re    = 1'b0;
        mem_addr  = '0;
        input_re  = 1'b0;
        busy      = 1'b1;
        done_all  = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                // Reads occupy the first 16 fetch cycles; the 17th only drains the last byte.
                if (!fetch_cnt[4]) begin
                    mem_re   = 1'b1;
                    mem_addr = tile_base + ADDR_W'(fetch_cnt[3:2]) * ROW_STEP
                               + ADDR_W'(fetch_cnt[1:0]);
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                input_re  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (result_we) begin
                    state_nxt = last_tile ? S_FINISH : S_FETCH;
                end
            end
            S_FINISH: begin
                done_all  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign input_addr = tile_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt     <= '0;
            tx            <= '0;
            ty            <= '0;
            tile_idx      <= '0;
            row_base      <= '0;
            tile_base     <= '0;
            rd_pend       <= 1'b0;
            rd_idx        <= '0;
            image_4x4     <= '0;
            conv_kernel_0 <= '0;
            conv_kernel_1 <= '0;
            conv_kernel_2 <= '0;
            shift         <= '0;
        end else begin
            rd_pend <= mem_re;
            rd_idx  <= fetch_cnt[3:0];
            if (rd_pend) begin
                image_4x4[{rd_idx, 3'b000} +: 8] <= mem_rdata;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        conv_kernel_0 <= cfg_kernel_0;
                        conv_kernel_1 <= cfg_kernel_1;
                        conv_kernel_2 <= cfg_kernel_2;
                        shift         <= cfg_shift;
                        tx            <= '0;
                        ty            <= '0;
                        tile_idx      <= '0;
                        row_base      <= base_addr;
                        tile_base     <= base_addr;
                        fetch_cnt     <= '0;
                    end
                end
                S_FETCH: begin
                    fetch_cnt <= fetch_cnt[4] ? 5'd0 : fetch_cnt + 5'd1;
                end
                S_WAIT: begin
                    // Tile origin is tracked incrementally so no multiply by the row pitch is needed.
                    if (result_we && !last_tile) begin
                        tile_idx  <= tile_idx + ADDR_W'(1);
                        fetch_cnt <= '0;
                        if (tx == LAST_TX) begin
                            tx        <= '0;
                            ty        <= ty + ADDR_W'(1);
                            row_base  <= row_base + ROW2_STEP;
                            tile_base <= row_base + ROW2_STEP;
                        end else begin
                            tx        <= tx + ADDR_W'(1);
                            tile_base <= tile_base + ADDR_W'(2);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_tile_feeder.sv
// Randomised scoreboard bench for conv_tile_feeder: a frame-level model queues expected
// SRAM addresses and tiles; monitor and engine processes check and respond independently.
module tb_conv_tile_feeder;

    localparam int IMG_W  = 6;
    localparam int IMG_H  = 6;
    localparam int ADDR_W = 16;
    localparam int TX     = (IMG_W - 4) / 2 + 1;
    localparam int TY     = (IMG_H - 4) / 2 + 1;
    localparam int TILES  = TX * TY;

    logic         clk;
    logic         rst;
    logic         start;
    logic [15:0]  base_addr;
    logic [71:0]  cfg_kernel_0, cfg_kernel_1, cfg_kernel_2;
    logic [1:0]   cfg_shift;
    logic         mem_re;
    logic [15:0]  mem_addr;
    logic [7:0]   mem_rdata;
    logic [127:0] image_4x4;
    logic [71:0]  conv_kernel_0, conv_kernel_1, conv_kernel_2;
    logic [1:0]   shift;
    logic         input_re;
    logic [15:0]  input_addr;
    logic         result_we;
    logic         busy;
    logic         done_all;

    typedef struct {
        logic [15:0]  idx;
        logic [127:0] img;
        logic [71:0]  k0;
        logic [71:0]  k1;
        logic [71:0]  k2;
        logic [1:0]   sh;
    } tile_t;

    tile_t       tile_q[$];
    logic [15:0] addr_q[$];

    int       n_checks = 0;
    int       n_fail = 0;
    int       cyc = 0;
    int       last_trigger = 0;
    int       mem_re_cnt = 0;
    bit       frame_done = 0;
    bit       prev_done = 0;
    logic [7:0] salt = 8'h00;
    int       dly_min = 5;
    int       dly_max = 5;
    bit       stray_en = 0;

    conv_tile_feeder #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .cfg_kernel_0(cfg_kernel_0), .cfg_kernel_1(cfg_kernel_1), .cfg_kernel_2(cfg_kernel_2),
        .cfg_shift(cfg_shift), .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .image_4x4(image_4x4), .conv_kernel_0(conv_kernel_0), .conv_kernel_1(conv_kernel_1),
        .conv_kernel_2(conv_kernel_2), .shift(shift), .input_re(input_re),
        .input_addr(input_addr), .result_we(result_we), .busy(busy), .done_all(done_all)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    function automatic logic [71:0] rand72();
        logic [95:0] tmp;
        tmp = {$urandom, $urandom, $urandom};
        return tmp[71:0];
    endfunction

    // Byte-wide SRAM whose content is address low byte xor a per-frame salt; 1-cycle read latency.
    initial begin
        logic        pend_v;
        logic [7:0]  pend_d;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            pend_v = mem_re;
            pend_d = mem_addr[7:0] ^ salt;
            @(posedge clk);
            #1 mem_rdata = pend_v ? pend_d : 8'($urandom);
        end
    end

    // Engine stand-in: answers each tile after a random delay, optionally with stray strobes outside WAIT.
    initial begin
        int cd;
        cd = -1;
        result_we = 1'b0;
        forever begin
            @(negedge clk);
            result_we = 1'b0;
            if (!rst) begin
                cd = -1;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        result_we    = 1'b1;
                        last_trigger = cyc;
                        cd           = -1;
                    end
                end
                if (input_re) begin
                    cd = $urandom_range(dly_max, dly_min);
                end
                if (stray_en && busy && !result_we && (cd == -1 || input_re)
                    && $urandom_range(3, 0) == 0) begin
                    result_we = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_done = 0;
            end else begin
                if (mem_re) begin
                    mem_re_cnt++;
                    if (addr_q.size() == 0) begin
                        checkOutput("unexpected_mem_re", mem_addr, 128'hFFFFFFFF);
                    end else begin
                        checkOutput("mem_addr", mem_addr, addr_q.pop_front());
                    end
                end
                if (input_re) begin
                    if (tile_q.size() == 0) begin
                        checkOutput("unexpected_input_re", 1, 0);
                    end else begin
                        tile_t t;
                        t = tile_q.pop_front();
                        checkOutput("input_addr", input_addr, t.idx);
                        checkOutput("image_4x4", image_4x4, t.img);
                        checkOutput("conv_kernel_0", conv_kernel_0, t.k0);
                        checkOutput("conv_kernel_1", conv_kernel_1, t.k1);
                        checkOutput("conv_kernel_2", conv_kernel_2, t.k2);
                        checkOutput("shift", shift, t.sh);
                        checkOutput("tile_latency", cyc - last_trigger, 18);
                    end
                end
                if (done_all) begin
                    checkOutput("done_single_pulse", prev_done, 0);
                    checkOutput("done_tiles_left", tile_q.size(), 0);
                    checkOutput("done_reads_left", addr_q.size(), 0);
                    checkOutput("frame_mem_re_count", mem_re_cnt, TILES * 16);
                    checkOutput("done_latency", cyc - last_trigger, 1);
                    frame_done = 1;
                    prev_done  = 1;
                end else if (prev_done) begin
                    checkOutput("busy_after_done", busy, 0);
                    prev_done = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] base, input logic [7:0] s);
        tile_t       t;
        logic [15:0] a;
        logic [71:0] k0, k1, k2;
        logic [1:0]  sh;
        k0   = rand72();
        k1   = rand72();
        k2   = rand72();
        sh   = 2'($urandom_range(3, 0));
        salt = s;
        for (int ty = 0; ty < TY; ty++) begin
            for (int tx = 0; tx < TX; tx++) begin
                t.idx = 16'(ty * TX + tx);
                t.img = '0;
                t.k0  = k0;
                t.k1  = k1;
                t.k2  = k2;
                t.sh  = sh;
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        a = base + 16'((2 * ty + r) * IMG_W + 2 * tx + c);
                        addr_q.push_back(a);
                        t.img[(r * 4 + c) * 8 +: 8] = a[7:0] ^ s;
                    end
                end
                tile_q.push_back(t);
            end
        end
        @(negedge clk);
        base_addr    = base;
        cfg_kernel_0 = k0;
        cfg_kernel_1 = k1;
        cfg_kernel_2 = k2;
        cfg_shift    = sh;
        start        = 1'b1;
        last_trigger = cyc;
        frame_done   = 0;
        mem_re_cnt   = 0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitFrame();
        int budget;
        budget = 0;
        while (!frame_done && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("frame_completed", frame_done, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_re"}, mem_re, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_image"}, image_4x4, 0);
        checkOutput({tag, "_kernel_0"}, conv_kernel_0, 0);
        checkOutput({tag, "_kernel_1"}, conv_kernel_1, 0);
        checkOutput({tag, "_kernel_2"}, conv_kernel_2, 0);
        checkOutput({tag, "_shift"}, shift, 0);
        checkOutput({tag, "_input_re"}, input_re, 0);
        checkOutput({tag, "_input_addr"}, input_addr, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done_all"}, done_all, 0);
    endtask

    initial begin
        int budget;
        rst          = 1'b0;
        start        = 1'b1;
        base_addr    = 16'h1234;
        cfg_kernel_0 = rand72();
        cfg_kernel_1 = rand72();
        cfg_kernel_2 = rand72();
        cfg_shift    = 2'd3;
        repeat (4) @(negedge clk);
        checkAllZero("reset");
        start = 1'b0;
        rst   = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_mem_re", mem_re, 0);

        $display("[TB] frame at base 0x0100 with fixed engine delay");
        applyStimulus(16'h0100, 8'h00);
        waitFrame();

        $display("[TB] frame with stray result_we and mid-fetch start/config changes");
        dly_min  = 1;
        dly_max  = 8;
        stray_en = 1;
        applyStimulus(16'($urandom), 8'($urandom));
        repeat (4) @(negedge clk);
        cfg_kernel_0 = ~cfg_kernel_0;
        cfg_shift    = ~cfg_shift;
        base_addr    = 16'($urandom);
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitFrame();

        $display("[TB] frame wrapping the address space");
        applyStimulus(16'hFFF8, 8'($urandom));
        waitFrame();

        $display("[TB] reset asserted while waiting for the engine");
        stray_en = 0;
        dly_min  = 20;
        dly_max  = 20;
        applyStimulus(16'($urandom), 8'($urandom));
        budget = 0;
        while (!input_re && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("first_input_re_seen", input_re, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkAllZero("abort");
        tile_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("post_abort_idle", busy, 0);

        dly_min  = 1;
        dly_max  = 8;
        stray_en = 1;
        for (int f = 0; f < 3; f++) begin
            applyStimulus(16'($urandom), 8'($urandom));
            waitFrame();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

endmodule
